scan_code_display_ctrl: RTL and testbench

- Sequencer between the PS/2 byte receiver and the 4-digit hex display decoder.
- Consumes single scan-code bytes and tracks prefix bytes (E0 extended, F0 break).
- Assembles complete make/break codes into the 16-bit word that drives the hex decoder, and holds that word until the next complete code.
- Abandons incomplete prefix sequences after a timeout.

---
 rtl/scan_code_display_if.sv | 23 ++
 rtl/scan_code_display_ctrl.sv | 116 +++++++++++
 tb/tb_scan_code_display_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/scan_code_display_if.sv
// Byte-in / code-out bundle between the PS/2 byte receiver, the scan-code
// sequencer and the hex display decoder.
interface scan_code_display_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [15:0] code;
    logic        code_valid;
    logic        key_down;
    logic        extended;
    logic        seq_err;

    // byte_valid is a one-cycle strobe with no ready: every strobe is consumed
    // in the cycle it is seen. code_valid and seq_err are one-cycle pulses.
    modport master (
        output byte_valid, byte_data,
        input  code, code_valid, key_down, extended, seq_err
    );

    modport slave (
        input  byte_valid, byte_data,
        output code, code_valid, key_down, extended, seq_err
    );
endinterface

// File: rtl/scan_code_display_ctrl.sv
// Assembles PS/2 scan-code bytes (E0/F0 prefixes) into a held 16-bit display word.
// Optional macro SCAN_CLEAR_ON_BREAK_EN: a completed break code loads 16'h0000.
module scan_code_display_ctrl #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    scan_code_display_if.slave   bus,
    output logic [1:0]           state_dbg
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GOT_E0    = 2'd1,
        GOT_F0    = 2'd2,
        GOT_E0_F0 = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      brk_code;

`ifdef SCAN_CLEAR_ON_BREAK_EN
    assign brk_code = 16'h0000;
`else
    assign brk_code = {PFX_BRK, bus.byte_data};
`endif

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.code       <= 16'h0000;
            bus.code_valid <= 1'b0;
            bus.key_down   <= 1'b0;
            bus.extended   <= 1'b0;
            bus.seq_err    <= 1'b0;
        end else begin
            bus.code_valid <= 1'b0;
            bus.seq_err    <= 1'b0;
            if (bus.byte_valid) begin
                // A byte always wins over a timeout expiring in the same cycle.
                cnt <= '0;
                case (state)
                    IDLE: begin
                        if (bus.byte_data == PFX_EXT) begin
                            state <= GOT_E0;
                        end else if (bus.byte_data == PFX_BRK) begin
                            state <= GOT_F0;
                        end else begin
                            bus.code       <= {8'h00, bus.byte_data};
                            bus.key_down   <= 1'b1;
                            bus.extended   <= 1'b0;
                            bus.code_valid <= 1'b1;
                        end
                    end
                    GOT_E0: begin
                        if (bus.byte_data == PFX_BRK) begin
                            state <= GOT_E0_F0;
                        end else if (bus.byte_data == PFX_EXT) begin
                            bus.seq_err <= 1'b1;
                        end else begin
                            bus.code       <= {PFX_EXT, bus.byte_data};
                            bus.key_down   <= 1'b1;
                            bus.extended   <= 1'b1;
                            bus.code_valid <= 1'b1;
                            state          <= IDLE;
                        end
                    end
                    GOT_F0: begin
                        if (bus.byte_data == PFX_BRK) begin
                            bus.seq_err <= 1'b1;
                        end else if (bus.byte_data == PFX_EXT) begin
                            bus.seq_err <= 1'b1;
                            state       <= GOT_E0;
                        end else begin
                            bus.code       <= brk_code;
                            bus.key_down   <= 1'b0;
                            bus.extended   <= 1'b0;
                            bus.code_valid <= 1'b1;
                            state          <= IDLE;
                        end
                    end
                    GOT_E0_F0: begin
                        if (bus.byte_data == PFX_EXT || bus.byte_data == PFX_BRK) begin
                            bus.seq_err <= 1'b1;
                        end else begin
                            bus.code       <= brk_code;
                            bus.key_down   <= 1'b0;
                            bus.extended   <= 1'b1;
                            bus.code_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (cnt == CNT_LAST) begin
                    bus.seq_err <= 1'b1;
                    state       <= IDLE;
                    cnt         <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_scan_code_display_ctrl.sv
// Directed bench for scan_code_display_ctrl: a vector table of single bytes
// plus hand sequences for reset, pulse width, timeout and mid-sequence reset.
module tb_scan_code_display_ctrl;
    localparam int TO = 8;
    localparam int W  = 22;  // {state, code_valid, seq_err, key_down, extended, code}

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] state_dbg;

    scan_code_display_if bus ();

    scan_code_display_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic [1:0]  st;
        logic        cv;
        logic        err;
        logic        kd;
        logic        ext;
        logic [15:0] code;
    } vec_t;

    logic [W-1:0] exp_q[$];
    vec_t tbl[$];
    int n_checks = 0;
    int n_pass = 0;

    function automatic logic [15:0] brk(input logic [7:0] b);
`ifdef SCAN_CLEAR_ON_BREAK_EN
        return 16'h0000;
`else
        return {8'hF0, b};
`endif
    endfunction

    function automatic logic [W-1:0] pack(input logic [1:0] st, input logic cv, input logic err,
                                          input logic kd, input logic ext, input logic [15:0] code);
        return {st, cv, err, kd, ext, code};
    endfunction

    // Compares the DUT outputs against the oldest entry of the expected queue.
    task automatic check(input string name);
        logic [W-1:0] got, exp;
        got = {state_dbg, bus.code_valid, bus.seq_err, bus.key_down, bus.extended, bus.code};
        exp = exp_q.pop_front();
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got st=%0d cv=%b err=%b kd=%b ext=%b code=%h, want st=%0d cv=%b err=%b kd=%b ext=%b code=%h",
                      name, got[21:20], got[19], got[18], got[17], got[16], got[15:0],
                      exp[21:20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    endtask

    // All driving happens at negedges; outputs are checked at the negedge after the capture edge.
    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add(input logic [7:0] b, input logic [1:0] st, input logic cv, input logic err,
                       input logic kd, input logic ext, input logic [15:0] code);
        vec_t v;
        v.b = b; v.st = st; v.cv = cv; v.err = err; v.kd = kd; v.ext = ext; v.code = code;
        tbl.push_back(v);
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // Back-to-back byte vectors, starting from the reset state.
        add(8'h1C, 2'd0, 1, 0, 1, 0, 16'h001C);
        add(8'hF0, 2'd2, 0, 0, 1, 0, 16'h001C);
        add(8'h1C, 2'd0, 1, 0, 0, 0, brk(8'h1C));
        add(8'hE0, 2'd1, 0, 0, 0, 0, brk(8'h1C));
        add(8'h75, 2'd0, 1, 0, 1, 1, 16'hE075);
        add(8'hE0, 2'd1, 0, 0, 1, 1, 16'hE075);
        add(8'hF0, 2'd3, 0, 0, 1, 1, 16'hE075);
        add(8'h75, 2'd0, 1, 0, 0, 1, brk(8'h75));
        add(8'hF0, 2'd2, 0, 0, 0, 1, brk(8'h75));
        add(8'hF0, 2'd2, 0, 1, 0, 1, brk(8'h75));
        add(8'h1C, 2'd0, 1, 0, 0, 0, brk(8'h1C));
        add(8'hE0, 2'd1, 0, 0, 0, 0, brk(8'h1C));
        add(8'hF0, 2'd3, 0, 0, 0, 0, brk(8'h1C));
        add(8'hE0, 2'd0, 0, 1, 0, 0, brk(8'h1C));
        add(8'hF0, 2'd2, 0, 0, 0, 0, brk(8'h1C));
        add(8'hE0, 2'd1, 0, 1, 0, 0, brk(8'h1C));
        add(8'hE0, 2'd1, 0, 1, 0, 0, brk(8'h1C));
        add(8'h5A, 2'd0, 1, 0, 1, 1, 16'hE05A);
        add(8'h00, 2'd0, 1, 0, 1, 0, 16'h0000);
        add(8'hE0, 2'd1, 0, 0, 1, 0, 16'h0000);
        add(8'hF0, 2'd3, 0, 0, 1, 0, 16'h0000);
        add(8'hF0, 2'd0, 0, 1, 1, 0, 16'h0000);

        // Reset state.
        idle(3);
        rst = 1'b0;
        exp_q.push_back(pack(2'd0, 0, 0, 0, 0, 16'h0000));
        check("reset");

        foreach (tbl[i]) exp_q.push_back(pack(tbl[i].st, tbl[i].cv, tbl[i].err,
                                              tbl[i].kd, tbl[i].ext, tbl[i].code));
        foreach (tbl[i]) begin
            send_byte(tbl[i].b);
            check($sformatf("vec%0d", i));
        end

        // code_valid is exactly one cycle wide and code is held afterwards.
        send_byte(8'h1C);
        exp_q.push_back(pack(2'd0, 1, 0, 1, 0, 16'h001C));
        check("make_1c");
        idle(1);
        exp_q.push_back(pack(2'd0, 0, 0, 1, 0, 16'h001C));
        check("cv_drop");
        idle(4);
        exp_q.push_back(pack(2'd0, 0, 0, 1, 0, 16'h001C));
        check("code_hold");

        // Break with a 3-cycle gap between prefix and code byte.
        send_byte(8'hF0);
        idle(3);
        send_byte(8'h1C);
        exp_q.push_back(pack(2'd0, 1, 0, 0, 0, brk(8'h1C)));
        check("brk_gap");

        // Timeout: F0 then silence; seq_err exactly 8 cycles after the byte edge.
        send_byte(8'h29);
        send_byte(8'hF0);
        for (int i = 1; i <= TO; i++) begin
            idle(1);
            if (i == TO) begin
                exp_q.push_back(pack(2'd0, 0, 1, 1, 0, 16'h0029));
                check("timeout_err");
            end else begin
                exp_q.push_back(pack(2'd2, 0, 0, 1, 0, 16'h0029));
                check($sformatf("timeout_wait%0d", i));
            end
        end
        idle(1);
        exp_q.push_back(pack(2'd0, 0, 0, 1, 0, 16'h0029));
        check("timeout_after");
        send_byte(8'h29);
        exp_q.push_back(pack(2'd0, 1, 0, 1, 0, 16'h0029));
        check("post_timeout_29");

        // Byte lands in the expiry cycle: byte wins, no timeout error.
        send_byte(8'hF0);
        idle(TO - 1);
        send_byte(8'h29);
        exp_q.push_back(pack(2'd0, 1, 0, 0, 0, brk(8'h29)));
        check("expiry_byte_wins");
        idle(1);
        exp_q.push_back(pack(2'd0, 0, 0, 0, 0, brk(8'h29)));
        check("expiry_no_err");

        // Reset mid-sequence discards the E0 prefix.
        send_byte(8'hE0);
        exp_q.push_back(pack(2'd1, 0, 0, 0, 0, brk(8'h29)));
        check("pre_rst_e0");
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_q.push_back(pack(2'd0, 0, 0, 0, 0, 16'h0000));
        check("mid_rst");
        send_byte(8'h1C);
        exp_q.push_back(pack(2'd0, 1, 0, 1, 0, 16'h001C));
        check("post_rst_1c");
        idle(1);
        exp_q.push_back(pack(2'd0, 0, 0, 1, 0, 16'h001C));
        check("post_rst_quiet");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
